// File: rtl/traceback_ctrl_if.sv
// Handshake/data bundle between the traceback controller, the key (time-index)
// register and the survivor-decision memory.
interface traceback_ctrl_if #(
  parameter int WORD_NUM     = 16,
  parameter int WORD_NUM_BIT = 4,
  parameter int STATE_BITS   = 2
);
  localparam int N = 1 << STATE_BITS;

  logic                    start;
  logic [STATE_BITS-1:0]   start_state;
  logic [WORD_NUM_BIT-1:0] last_index;
  logic [WORD_NUM_BIT-1:0] key_i;
  logic                    RW_Key_reg;
  logic [WORD_NUM_BIT-1:0] key_Key_reg;
  logic                    decrement_enable;
  logic [WORD_NUM_BIT-1:0] surv_addr;
  logic [N-1:0]            surv_data;
  logic                    bit_valid;
  logic                    bit_out;
  logic [WORD_NUM-1:0]     decoded_word;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, start_state, last_index, key_i, surv_data,
    output RW_Key_reg, key_Key_reg, decrement_enable, surv_addr,
           bit_valid, bit_out, decoded_word, busy, done
  );

  modport master (
    output start, start_state, last_index, key_i, surv_data,
    input  RW_Key_reg, key_Key_reg, decrement_enable, surv_addr,
           bit_valid, bit_out, decoded_word, busy, done
  );
endinterface

// File: rtl/traceback_ctrl.sv
// Viterbi traceback controller: loads the key register with the last trellis
// index, then walks the survivor memory backwards one index per cycle.
//
// state  | meaning
// IDLE   | waiting for start; captures start_state/last_index on start
// LOAD   | strobes RW_Key_reg with the captured last index
// TRACE  | one survivor step per cycle, key register decrements until 0
// FINISH | one-cycle done pulse, starts ignored
module traceback_ctrl #(
  parameter int WORD_NUM     = 16,
  parameter int WORD_NUM_BIT = 4,
  parameter int STATE_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  traceback_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    TRACE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [STATE_BITS-1:0]   cur_state_q, cur_state_d;
  logic [WORD_NUM_BIT-1:0] idx_cap_q, idx_cap_d;
  logic [WORD_NUM-1:0]     decoded_word_q, decoded_word_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;
  logic                    surv_bit;
  logic                    key_zero;

  assign surv_bit = bus.surv_data[cur_state_q];
  assign key_zero = (bus.key_i == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cur_state_q    <= '0;
      idx_cap_q      <= '0;
      decoded_word_q <= '0;
      bit_out_q      <= 1'b0;
      bit_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_state_q    <= cur_state_d;
      idx_cap_q      <= idx_cap_d;
      decoded_word_q <= decoded_word_d;
      bit_out_q      <= bit_out_d;
      bit_valid_q    <= bit_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cur_state_d    = cur_state_q;
    idx_cap_d      = idx_cap_q;
    decoded_word_d = decoded_word_q;
    bit_out_d      = bit_out_q;
    bit_valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_state_d    = bus.start_state;
          idx_cap_d      = bus.last_index;
          decoded_word_d = '0;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        state_d = TRACE;
      end
      TRACE: begin
        // The emitted bit is the MSB of the state before shifting in the decision.
        bit_out_d                 = cur_state_q[STATE_BITS-1];
        bit_valid_d               = 1'b1;
        decoded_word_d[bus.key_i] = cur_state_q[STATE_BITS-1];
        cur_state_d               = {cur_state_q[STATE_BITS-2:0], surv_bit};
        if (key_zero) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.RW_Key_reg       = (state_q == LOAD);
  assign bus.key_Key_reg      = idx_cap_q;
  assign bus.decrement_enable = (state_q == TRACE) && !key_zero;
  assign bus.surv_addr        = bus.key_i;
  assign bus.busy             = (state_q == LOAD) || (state_q == TRACE);
  assign bus.done             = (state_q == FINISH);
  assign bus.bit_valid        = bit_valid_q;
  assign bus.bit_out          = bit_out_q;
  assign bus.decoded_word     = decoded_word_q;

endmodule

// File: tb/tb_traceback_ctrl.sv
// Self-checking bench for traceback_ctrl: models the key register and survivor
// memory, compares against a trellis-walk reference model.
module tb_traceback_ctrl;

  logic clk;
  logic rst_n;

  traceback_ctrl_if #(.WORD_NUM(16), .WORD_NUM_BIT(4), .STATE_BITS(2)) bus ();

  traceback_ctrl #(.WORD_NUM(16), .WORD_NUM_BIT(4), .STATE_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key register: load beats decrement, never wraps below 0
  logic [3:0] key_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else if (bus.RW_Key_reg) key_q <= bus.key_Key_reg;
    else if (bus.decrement_enable && key_q != 4'd0) key_q <= key_q - 4'd1;
  end
  assign bus.key_i = key_q;

  logic [3:0] mem [16];
  always_comb bus.surv_data = mem[bus.surv_addr];

  int total = 0;
  int bad   = 0;
  logic [15:0] prev_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: walk the trellis backwards from the end state.
  function automatic logic [15:0] model_word(input logic [1:0] ss, input int li);
    logic [15:0] w = '0;
    int cs = ss;
    for (int k = li; k >= 0; k--) begin
      w[k] = (cs >= 2);
      cs = ((cs * 2) % 4) + int'(mem[k][cs]);
    end
    return w;
  endfunction

  task automatic fill_mem(input logic [3:0] v);
    for (int a = 0; a < 16; a++) mem[a] = v;
  endtask

  task automatic run(input string tag, input logic [1:0] ss, input logic [3:0] li,
                     input logic [15:0] exp_word, input bit poke);
    int lat = 0, rw = 0, dec = 0, ovl = 0, nbits = 0;
    logic [15:0] stream_word = '0;
    @(negedge clk);
    chk({tag, " idle busy"}, bus.busy, 0);
    chk({tag, " word held"}, bus.decoded_word, prev_word);
    bus.start = 1'b1; bus.start_state = ss; bus.last_index = li;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.RW_Key_reg) rw++;
      if (bus.decrement_enable) dec++;
      if (bus.RW_Key_reg && bus.decrement_enable) ovl++;
      if (c == 1) chk({tag, " load strobe"}, bus.RW_Key_reg, 1);
      if (bus.bit_valid) begin
        if (nbits <= int'(li)) stream_word[int'(li) - nbits] = bus.bit_out;
        nbits++;
      end
      if (bus.done) begin
        lat = c;
        if (poke) begin
          bus.start = 1'b1; bus.start_state = ~ss; bus.last_index = 4'd2;
        end
        break;
      end
      if (poke && c == 3) begin
        bus.start = 1'b1; bus.start_state = ~ss; bus.last_index = li ^ 4'd5;
      end
    end
    chk({tag, " latency"}, lat, int'(li) + 3);
    chk({tag, " word"}, bus.decoded_word, exp_word);
    chk({tag, " bit stream"}, stream_word, exp_word);
    chk({tag, " nbits"}, nbits, int'(li) + 1);
    chk({tag, " dec pulses"}, dec, int'(li));
    chk({tag, " rw pulses"}, rw, 1);
    chk({tag, " overlap"}, ovl, 0);
    prev_word = exp_word;
  endtask

  typedef struct {
    logic [1:0]  ss;
    logic [3:0]  li;
    logic [3:0]  fill;
    logic [15:0] exp_word;
    bit          poke;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{ss: 2'b11, li: 4'd3,  fill: 4'h0, exp_word: 16'h000C, poke: 1'b0};
    vecs[1] = '{ss: 2'b00, li: 4'd15, fill: 4'hF, exp_word: 16'h3FFF, poke: 1'b0};
    vecs[2] = '{ss: 2'b10, li: 4'd0,  fill: 4'h0, exp_word: 16'h0001, poke: 1'b0};
    vecs[3] = '{ss: 2'b01, li: 4'd1,  fill: 4'h0, exp_word: 16'h0001, poke: 1'b0};
    vecs[4] = '{ss: 2'b11, li: 4'd5,  fill: 4'h0, exp_word: 16'h0030, poke: 1'b1};

    bus.start = 1'b0; bus.start_state = '0; bus.last_index = '0;
    fill_mem(4'h0);
    prev_word = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset strobes", {bus.RW_Key_reg, bus.decrement_enable, bus.bit_valid}, 0);
    chk("reset word", {bus.decoded_word, 15'd0, bus.bit_out}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      fill_mem(vecs[i].fill);
      run($sformatf("vec%0d", i), vecs[i].ss, vecs[i].li, vecs[i].exp_word, vecs[i].poke);
    end
    // chained run right after a poked FINISH: garbage start must have been dropped
    fill_mem(4'h0);
    run("after poke", 2'b10, 4'd2, 16'h0004, 1'b0);

    // reset during the 5th TRACE step
    fill_mem(4'hF);
    @(negedge clk);
    bus.start = 1'b1; bus.start_state = 2'b00; bus.last_index = 4'd15;
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrst busy before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst strobes", {bus.RW_Key_reg, bus.decrement_enable, bus.bit_valid}, 0);
    chk("midrst word", bus.decoded_word, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_word = '0;
    run("post reset", 2'b00, 4'd15, 16'h3FFF, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [1:0] ss;
      logic [3:0] li;
      for (int a = 0; a < 16; a++) mem[a] = 4'($urandom_range(0, 15));
      ss = 2'($urandom_range(0, 3));
      li = 4'($urandom_range(0, 15));
      run($sformatf("rand%0d", r), ss, li, model_word(ss, int'(li)), $urandom_range(0, 3) == 0);
    end

    repeat (2) @(negedge clk);
    chk("final hold", bus.decoded_word, prev_word);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
